// File: rtl/npu_ccreg_bank.sv
// NPU control/configuration register bank.
// Single-cycle registered bus response. W1C interrupt status with a registered
// irq. The CFG words are snapshotted into shadow registers on START, so the
// host can reprogram CFG while the NPU runs.
module npu_ccreg_bank #(
  parameter int                ADDR_W    = 32,
  parameter int                OS_W      = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                DW        = 64,
  parameter int                CFG_DEPTH = 8
) (
  input  logic                    clk_trans,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       reg_addr,
  input  logic [DW-1:0]           reg_wdata,
  input  logic [DW/8-1:0]         reg_sel,
  input  logic                    reg_wen,
  input  logic                    reg_ren,
  output logic [DW-1:0]           reg_rdata,
  output logic                    reg_ack,
  output logic                    reg_err,
  input  logic                    npu_busy,
  input  logic                    img_expired_flg,
  output logic                    npu_en_processing,
  output logic                    npu_init_cmplt,
  output logic                    nn_img_new,
  output logic                    npu_start,
  output logic                    irq,
  output logic [CFG_DEPTH*DW-1:0] cfg_shadow
);

  // Handshake: a cycle with (reg_wen | reg_ren) on an address in this page is a
  // request. It is answered by a one-cycle reg_ack on the next cycle, with
  // reg_rdata and reg_err valid only while reg_ack is high (both 0 otherwise).
  // There is no back-pressure, and unselected addresses never get an ack.

  localparam int IDX_W    = OS_W - 3;
  localparam int NB       = DW / 8;
  localparam int CFG_BASE = 'h80;  // byte offset 0x400 / 8

  logic [IDX_W-1:0]          word_idx;
  logic                      page_hit;
  logic                      req;
  logic                      is_en, is_ctrl, is_stat, is_irq_en, is_irq_stat;
  logic [CFG_DEPTH-1:0]      cfg_hit_vec;
  logic                      cfg_hit;
  logic [DW-1:0]             cfg_rd;
  logic [DW-1:0]             wmask;
  logic                      start_req;
  logic                      err_c;
  logic                      wr_ok;
  logic                      start_go;
  logic [DW-1:0]             rd_val;
  logic [1:0]                w1c;
  logic                      busy_fall;
  logic                      unused_addr_lsb;

  logic                      en_q, init_q, img_q, locked_q, busy_d, start_q, irq_q;
  logic [1:0]                irq_en_q, irq_stat_q;
  logic [CFG_DEPTH*DW-1:0]   cfg_q, shadow_q;
  logic [DW-1:0]             rdata_q;
  logic                      ack_q, err_q;

  assign word_idx        = reg_addr[OS_W-1:3];
  assign page_hit        = (reg_addr[ADDR_W-1:OS_W] == BASE_ADDR[ADDR_W-1:OS_W]);
  assign req             = (reg_wen | reg_ren) & page_hit;
  assign unused_addr_lsb = ^reg_addr[2:0];
  assign busy_fall       = busy_d & ~npu_busy;

  // Address decode, CFG read mux and byte-lane write mask.
  always_comb begin
    is_en       = (word_idx == IDX_W'(0));
    is_ctrl     = (word_idx == IDX_W'(1));
    is_stat     = (word_idx == IDX_W'(2));
    is_irq_en   = (word_idx == IDX_W'(3));
    is_irq_stat = (word_idx == IDX_W'(4));
    cfg_hit_vec = '0;
    cfg_rd      = '0;
    for (int i = 0; i < CFG_DEPTH; i++) begin
      if (word_idx == IDX_W'(CFG_BASE + i)) begin
        cfg_hit_vec[i] = 1'b1;
        cfg_rd         = cfg_q[i*DW +: DW];
      end
    end
    cfg_hit = |cfg_hit_vec;
    wmask   = '0;
    for (int b = 0; b < NB; b++) begin
      wmask[b*8 +: 8] = {8{reg_sel[b]}};
    end
  end

  // Error classification, write qualification and read data selection.
  always_comb begin
    start_req = reg_wen & is_ctrl & reg_sel[0] & reg_wdata[2];
    err_c     = (reg_wen & reg_ren)
              | ~(is_en | is_ctrl | is_stat | is_irq_en | is_irq_stat | cfg_hit)
              | (reg_wen & is_stat)
              | (reg_wen & cfg_hit & locked_q)
              | (start_req & (~en_q | locked_q));
    wr_ok     = req & reg_wen & ~err_c;
    start_go  = wr_ok & start_req;
    w1c       = (wr_ok & is_irq_stat & reg_sel[0]) ? reg_wdata[1:0] : 2'b00;
    rd_val    = '0;
    if (is_en)            rd_val[0]   = en_q;
    else if (is_ctrl)     rd_val[1:0] = {img_q, init_q};
    else if (is_stat)     rd_val[1:0] = {locked_q, npu_busy};
    else if (is_irq_en)   rd_val[1:0] = irq_en_q;
    else if (is_irq_stat) rd_val[1:0] = irq_stat_q;
    else if (cfg_hit)     rd_val      = cfg_rd;
  end

  // Control, status and interrupt registers; hardware sets win over W1C.
  always_ff @(posedge clk_trans or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      init_q     <= 1'b0;
      img_q      <= 1'b0;
      locked_q   <= 1'b0;
      busy_d     <= 1'b0;
      start_q    <= 1'b0;
      irq_q      <= 1'b0;
      irq_en_q   <= 2'b00;
      irq_stat_q <= 2'b00;
    end else begin
      busy_d     <= npu_busy;
      start_q    <= start_go;
      irq_q      <= |(irq_stat_q & irq_en_q);
      irq_stat_q <= (irq_stat_q & ~w1c) | {img_expired_flg, busy_fall};
      if (wr_ok & is_en & reg_sel[0])     en_q     <= reg_wdata[0];
      if (wr_ok & is_ctrl & reg_sel[0])   init_q   <= reg_wdata[0];
      if (wr_ok & is_irq_en & reg_sel[0]) irq_en_q <= reg_wdata[1:0];
      if (wr_ok & is_ctrl & reg_sel[0] & reg_wdata[1]) img_q <= 1'b1;
      else if (img_expired_flg)                        img_q <= 1'b0;
      if (start_go)       locked_q <= 1'b1;
      else if (busy_fall) locked_q <= 1'b0;
    end
  end

  // CFG words with byte-lane writes.
  always_ff @(posedge clk_trans or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
    end else begin
      for (int i = 0; i < CFG_DEPTH; i++) begin
        if (wr_ok & cfg_hit_vec[i]) begin
          cfg_q[i*DW +: DW] <= (cfg_q[i*DW +: DW] & ~wmask) | (reg_wdata & wmask);
        end
      end
    end
  end

  // Shadow snapshot of all CFG words on an accepted START.
  always_ff @(posedge clk_trans or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (start_go) begin
      shadow_q <= cfg_q;
    end
  end

  // Registered bus response: ack one cycle after the request.
  always_ff @(posedge clk_trans or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= req;
      err_q   <= req & err_c;
      rdata_q <= (req & ~err_c & reg_ren) ? rd_val : '0;
    end
  end

  assign reg_ack           = ack_q;
  assign reg_err           = err_q;
  assign reg_rdata         = rdata_q;
  assign npu_en_processing = en_q;
  assign npu_init_cmplt    = init_q;
  assign nn_img_new        = img_q;
  assign npu_start         = start_q;
  assign irq               = irq_q;
  assign cfg_shadow        = shadow_q;

endmodule

// File: tb/tb_npu_ccreg_bank.sv
// Testbench for npu_ccreg_bank: directed scenarios plus random traffic,
// checked against a register-level reference model through an expected queue.
module tb_npu_ccreg_bank;

  localparam int DW = 64;
  localparam int D  = 8;

  // ---------------- clock / reset ----------------
  logic clk_trans = 1'b0;
  logic rst_n     = 1'b0;
  always #5 clk_trans = ~clk_trans;

  // ---------------- main DUT ----------------
  logic [31:0]     reg_addr;
  logic [DW-1:0]   reg_wdata;
  logic [DW/8-1:0] reg_sel;
  logic            reg_wen, reg_ren;
  logic [DW-1:0]   reg_rdata;
  logic            reg_ack, reg_err;
  logic            npu_busy, img_expired_flg;
  logic            npu_en_processing, npu_init_cmplt, nn_img_new, npu_start, irq;
  logic [D*DW-1:0] cfg_shadow;

  npu_ccreg_bank u_dut (
    .clk_trans(clk_trans), .rst_n(rst_n),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_sel(reg_sel),
    .reg_wen(reg_wen), .reg_ren(reg_ren),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_err(reg_err),
    .npu_busy(npu_busy), .img_expired_flg(img_expired_flg),
    .npu_en_processing(npu_en_processing), .npu_init_cmplt(npu_init_cmplt),
    .nn_img_new(nn_img_new), .npu_start(npu_start), .irq(irq),
    .cfg_shadow(cfg_shadow)
  );

  // ---------------- small build: DW=32, CFG_DEPTH=1 ----------------
  logic [31:0] s_addr, s_wdata, s_rdata, s_cfg;
  logic [3:0]  s_sel;
  logic        s_wen, s_ren, s_ack, s_err;
  logic        s_en, s_init, s_img, s_start, s_irq;

  npu_ccreg_bank #(.DW(32), .CFG_DEPTH(1)) u_small (
    .clk_trans(clk_trans), .rst_n(rst_n),
    .reg_addr(s_addr), .reg_wdata(s_wdata), .reg_sel(s_sel),
    .reg_wen(s_wen), .reg_ren(s_ren),
    .reg_rdata(s_rdata), .reg_ack(s_ack), .reg_err(s_err),
    .npu_busy(1'b0), .img_expired_flg(1'b0),
    .npu_en_processing(s_en), .npu_init_cmplt(s_init),
    .nn_img_new(s_img), .npu_start(s_start), .irq(s_irq),
    .cfg_shadow(s_cfg)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [DW:0] exp_q[$];  // {err, rdata}

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every ack pops one expectation; idle cycles must show zero data.
  always @(negedge clk_trans) begin
    if (rst_n) begin
      if (reg_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 1'b1, 1'b0);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          chk("resp", {reg_err, reg_rdata}, e);
        end
      end else if (reg_err || reg_rdata != '0) begin
        chk("idle_resp", {reg_err, reg_rdata}, '0);
      end
    end
  end

  // ---------------- reference model ----------------
  logic          m_en, m_init, m_img, m_locked, m_busy_d, m_irq, m_start;
  logic [1:0]    m_ien, m_ist;
  logic [DW-1:0] m_cfg[D];
  logic [DW-1:0] m_shadow[D];
  logic          busy_lvl   = 1'b0;
  logic          exp_pulse  = 1'b0;

  task automatic model_reset();
    m_en = 0; m_init = 0; m_img = 0; m_locked = 0; m_busy_d = 0; m_irq = 0; m_start = 0;
    m_ien = 0; m_ist = 0;
    for (int i = 0; i < D; i++) begin m_cfg[i] = '0; m_shadow[i] = '0; end
  endtask

  task automatic check_outputs();
    logic [D*DW-1:0] sh;
    for (int i = 0; i < D; i++) sh[i*DW +: DW] = m_shadow[i];
    chk("en_out", npu_en_processing, m_en);
    chk("init_cmplt", npu_init_cmplt, m_init);
    chk("img_new", nn_img_new, m_img);
    chk("start", npu_start, m_start);
    chk("irq", irq, m_irq);
    chk("shadow", cfg_shadow, sh);
  endtask

  // One bus cycle: drive at negedge, advance the model, check at next negedge.
  task automatic cyc(input logic w, input logic r, input logic [31:0] a,
                     input logic [DW-1:0] d, input logic [7:0] s);
    logic [11:0]   off;
    logic          hit, err, doit, start, fall, n_irq, img_set;
    logic [DW-1:0] rv;
    logic [1:0]    clr;
    int            k;
    reg_wen = w; reg_ren = r; reg_addr = a; reg_wdata = d; reg_sel = s;
    npu_busy = busy_lvl; img_expired_flg = exp_pulse;
    off = {a[11:3], 3'b000};
    hit = (w || r) && (a[31:12] == 20'h0);
    err = (w && r);
    rv  = '0;
    k   = -1;
    case (off)
      12'h000: rv = DW'(m_en);
      12'h008: begin
        rv = DW'({m_img, m_init});
        if (w && s[0] && d[2] && (!m_en || m_locked)) err = 1;
      end
      12'h010: begin rv = DW'({m_locked, busy_lvl}); if (w) err = 1; end
      12'h018: rv = DW'(m_ien);
      12'h020: rv = DW'(m_ist);
      default: begin
        if (off >= 12'h400 && off < 12'h400 + 12'(8 * D)) begin
          k  = int'((off - 12'h400) >> 3);
          rv = m_cfg[k];
          if (w && m_locked) err = 1;
        end else begin
          err = 1;
        end
      end
    endcase
    if (err || !r) rv = '0;
    if (hit) exp_q.push_back({err, rv});
    // state evolution
    doit    = hit && w && !err;
    fall    = m_busy_d && !busy_lvl;
    start   = doit && off == 12'h008 && s[0] && d[2];
    img_set = doit && off == 12'h008 && s[0] && d[1];
    n_irq   = |(m_ist & m_ien);
    clr     = (doit && off == 12'h020 && s[0]) ? d[1:0] : 2'b00;
    if (start) for (int i = 0; i < D; i++) m_shadow[i] = m_cfg[i];
    if (doit && s[0] && off == 12'h000) m_en = d[0];
    if (doit && s[0] && off == 12'h008) m_init = d[0];
    if (doit && s[0] && off == 12'h018) m_ien = d[1:0];
    if (doit && k >= 0)
      for (int b = 0; b < 8; b++) if (s[b]) m_cfg[k][8*b +: 8] = d[8*b +: 8];
    if (img_set) m_img = 1;
    else if (exp_pulse) m_img = 0;
    m_ist = (m_ist & ~clr) | {exp_pulse, fall};
    if (start) m_locked = 1;
    else if (fall) m_locked = 0;
    m_irq = n_irq; m_start = start; m_busy_d = busy_lvl;
    @(negedge clk_trans);
    reg_wen = 0; reg_ren = 0; exp_pulse = 0; img_expired_flg = 0;
    check_outputs();
  endtask

  task automatic wr(input logic [31:0] a, input logic [DW-1:0] d, input logic [7:0] s);
    cyc(1'b1, 1'b0, a, d, s);
  endtask
  task automatic rd(input logic [31:0] a);
    cyc(1'b0, 1'b1, a, '0, 8'h00);
  endtask
  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, '0, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reg_addr = 0; reg_wdata = 0; reg_sel = 0; reg_wen = 0; reg_ren = 0;
    npu_busy = 0; img_expired_flg = 0;
    s_addr = 0; s_wdata = 0; s_sel = 0; s_wen = 0; s_ren = 0;
    model_reset();
    repeat (3) @(negedge clk_trans);
    rst_n = 1'b1;
    chk("rst_ack", reg_ack, 1'b0);
    chk("rst_outs", {npu_en_processing, npu_init_cmplt, nn_img_new, npu_start, irq}, 5'b0);
    chk("rst_shadow", cfg_shadow, '0);

    // Reset readback and byte-lane write
    rd(32'h400);
    chk("cfg0_reset_read", {reg_ack, reg_err, reg_rdata}, {2'b10, 64'h0});
    wr(32'h410, 64'h1122_3344_5566_7788, 8'hFF);
    wr(32'h410, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    rd(32'h410);
    chk("cfg2_bytelane", reg_rdata, 64'h1122_3344_AAAA_AAAA);

    // START with EN=0 is refused
    wr(32'h008, 64'h4, 8'h01);
    chk("start_no_en_err", reg_err, 1'b1);

    // START sequence and CFG lock
    wr(32'h000, 64'h1, 8'hFF);
    wr(32'h400, 64'h5, 8'hFF);
    wr(32'h008, 64'h4, 8'h01);
    chk("start_pulse", npu_start, 1'b1);
    chk("shadow0", cfg_shadow[63:0], 64'h5);
    rd(32'h010);
    chk("stat_locked", reg_rdata, 64'h2);
    chk("start_one_cycle", npu_start, 1'b0);
    wr(32'h400, 64'h7, 8'hFF);
    chk("cfg_locked_err", reg_err, 1'b1);
    rd(32'h400);
    chk("cfg0_kept", reg_rdata, 64'h5);

    // Busy fall: done status, unlock, irq, W1C
    busy_lvl = 1; idle(); idle();
    wr(32'h018, 64'h1, 8'h01);
    busy_lvl = 0; idle(); idle();
    chk("irq_done", irq, 1'b1);
    rd(32'h020);
    chk("irq_stat_done", reg_rdata, 64'h1);
    rd(32'h010);
    chk("unlocked", reg_rdata, 64'h0);
    wr(32'h020, 64'h1, 8'h01);
    idle();
    chk("irq_cleared", irq, 1'b0);
    busy_lvl = 1; idle();
    busy_lvl = 0; wr(32'h020, 64'h1, 8'h01);
    rd(32'h020);
    chk("set_beats_w1c", reg_rdata, 64'h1);

    // Error cases and unselected page
    rd(32'h440);
    chk("cfg_oob_err", reg_err, 1'b1);
    rd(32'h030);
    chk("unmapped_err", reg_err, 1'b1);
    cyc(1'b1, 1'b1, 32'h000, 64'h0, 8'hFF);
    chk("wen_ren_err", reg_err, 1'b1);
    rd(32'h0000_1000);
    chk("out_of_page_no_ack", reg_ack, 1'b0);

    // img_new set then expired
    wr(32'h008, 64'h2, 8'h01);
    chk("img_new_set", nn_img_new, 1'b1);
    exp_pulse = 1; idle();
    chk("img_new_clr", nn_img_new, 1'b0);
    rd(32'h020);
    chk("irq_stat_img", reg_rdata, 64'h3);

    // Reset with a response in flight drops it
    reg_ren = 1; reg_addr = 32'h0;
    @(posedge clk_trans); #1;
    rst_n = 0; #1;
    chk("pending_ack_dropped", reg_ack, 1'b0);
    reg_ren = 0;
    @(negedge clk_trans);
    chk("midrst_outs", {npu_en_processing, npu_init_cmplt, nn_img_new, npu_start, irq, reg_err}, 6'b0);
    chk("midrst_shadow", cfg_shadow, '0);
    rst_n = 1;
    model_reset();
    busy_lvl = 0;

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      logic [31:0]   a;
      logic [DW-1:0] d;
      logic [7:0]    s;
      int            op;
      if ($urandom_range(0, 7) == 0) busy_lvl = ~busy_lvl;
      exp_pulse = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 11))
        0: a = 32'h000;  1, 10: a = 32'h008;  2: a = 32'h010;
        3: a = 32'h018;  4: a = 32'h020;      8: a = 32'h030;
        9: a = 32'h0000_1000;                 11: a = 32'h3F8;
        default: a = 32'h400 + 32'(8 * $urandom_range(0, 9));
      endcase
      a[2:0] = 3'($urandom_range(0, 7));
      d = {$urandom, $urandom};
      s = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      op = $urandom_range(0, 19);
      if (op < 4)       idle();
      else if (op < 11) cyc(1'b0, 1'b1, a, d, s);
      else if (op < 19) cyc(1'b1, 1'b0, a, d, s);
      else              cyc(1'b1, 1'b1, a, d, s);
    end
    busy_lvl = 0;
    repeat (3) idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // Small build: single CFG word, 32-bit data
    s_ren = 1; s_addr = 32'h408;
    @(negedge clk_trans); s_ren = 0;
    chk("small_cfg1_err", {s_ack, s_err, s_rdata}, {2'b11, 32'h0});
    s_wen = 1; s_addr = 32'h400; s_wdata = 32'hDEAD_BEEF; s_sel = 4'h3;
    @(negedge clk_trans); s_wen = 0;
    chk("small_wr_ack", {s_ack, s_err}, 2'b10);
    s_ren = 1; s_addr = 32'h400;
    @(negedge clk_trans); s_ren = 0;
    chk("small_cfg0_read", {s_ack, s_err, s_rdata}, {2'b10, 32'h0000_BEEF});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/npu_ccreg_bank.md
Name: npu_ccreg_bank

Overview:
- Parametrised control/configuration register bank for the NPU. It sits between the bus interface unit and the MCU.
- Adds the following over the previous fixed register bank:
  - configurable CFG depth and data width
  - byte-lane writes
  - registered ack/err response
  - write-1-to-clear interrupt status with an irq output
  - shadow copies of the CFG registers, captured on a start pulse, so the host can reprogram CFG while the NPU runs.

Parameters:
- ADDR_W, 32, bus address width.
- OS_W, 12, offset field width. The block is selected when addr[ADDR_W-1:OS_W] == BASE_ADDR>>OS_W.
- BASE_ADDR, 32'h0000_0000, page base address (aligned to 2^OS_W).
- DW, 64, data width. Must be a multiple of 8, ≥32.
- CFG_DEPTH, 8, number of CFG words, 1..64.

Ports:
- clk_trans  in  1  clock
- rst_n  in  1  async active-low reset
- reg_addr  in  ADDR_W  byte address
- reg_wdata  in  DW  write data
- reg_sel  in  DW/8  byte enables
- reg_wen  in  1  one-cycle write request
- reg_ren  in  1  one-cycle read request
- reg_rdata  out  DW  read data, valid with ack
- reg_ack  out  1  response strobe
- reg_err  out  1  error, valid with ack
- npu_busy  in  1  NPU busy level
- img_expired_flg  in  1  first-map consumed pulse
- npu_en_processing  out  1  EN[0]
- npu_init_cmplt  out  1  CTRL[0]
- nn_img_new  out  1  CTRL[1]
- npu_start  out  1  one-cycle start pulse
- irq  out  1  interrupt
- cfg_shadow  out  CFG_DEPTH*DW  shadow CFG words, flattened, word i at [i*DW +: DW]

Behaviour:
- Clock and reset: clk_trans, with asynchronous active-low rst_n.
- Reset values: all registers, shadows and outputs are 0.
- Register map (offsets, 8-byte words; index = addr[OS_W-1:3]):
  - 0x000 EN, RW, bit0.
  - 0x008 CTRL:
    - bit0 init_cmplt, RW.
    - bit1 img_new: set by writing 1; cleared by img_expired_flg; set wins if both occur in the same cycle.
    - bit2 START: write-only; always reads 0.
  - 0x010 STAT, RO: bit0 npu_busy, bit1 locked (start issued, not yet done).
  - 0x018 IRQ_EN, RW, bits[1:0].
  - 0x020 IRQ_STAT, W1C, bits[1:0]:
    - bit0 done: set on the cycle after npu_busy falls.
    - bit1 img_expired: set on img_expired_flg.
    - A hardware set wins over a simultaneous W1C.
  - 0x400 + 8*i CFG[i], RW, for i < CFG_DEPTH.
- Byte enables: writes apply reg_sel per byte to all RW registers. For control bits, reg_sel[0] gates bits 7:0. For W1C, only selected bytes clear.
- Handshake:
  - A request is a cycle with (reg_wen|reg_ren) and the block selected.
  - reg_ack pulses exactly 1 cycle later; reg_rdata and reg_err are registered with it.
  - No ack is ever generated for an unselected address.
  - A write takes effect on the request edge, so a read issued in the next cycle returns the new value.
  - Outside ack, reg_rdata = 0 and reg_err = 0.
- Error cases (ack=1, err=1, no state change):
  - reg_wen and reg_ren high together.
  - Unmapped offset, or CFG index ≥ CFG_DEPTH.
  - Write to STAT.
  - Write to CFG while locked.
- Error reads return 0. Reads of valid registers zero-extend to DW.
- Start:
  - A write to CTRL with bit2=1, byte 0 selected, EN[0]=1, and not locked produces the following on the next cycle:
    - npu_start=1 for one cycle
    - cfg_shadow[i] <= CFG[i] for all i
    - locked <= 1
  - A START write while EN[0]=0 or while locked is acked with err=1 and does not pulse.
- locked clears on the cycle after npu_busy falls, together with IRQ_STAT[0] being set.
- Clearing EN[0] while locked does not clear locked.
- irq = |(IRQ_STAT & IRQ_EN), registered (1 cycle after the status update).
- npu_busy is sampled with a 1-flop delay for falling-edge detection. The delay flop resets to 0, so a reset-release with busy=0 generates no event.
- Reset mid-operation: all state returns to 0 immediately. A response pending at reset is dropped (no ack).

Test Plan:
- Reset → all outputs 0; read CFG[0] → ack after 1 cycle, rdata=0, err=0.
- Write CFG[2]=64'h1122_3344_5566_7788, sel=8'hFF; then write 64'hAAAA_AAAA_AAAA_AAAA with sel=8'h0F → readback 64'h1122_3344_AAAA_AAAA.
- EN=1, CFG[0]=64'h5; START → npu_start one pulse, cfg_shadow[63:0]=5, STAT=2'b10. Then write CFG[0]=7 → err=1, CFG[0] stays 5.
- Drive npu_busy 1→0 with IRQ_EN=1 → IRQ_STAT=1, locked=0, irq=1; W1C 0x020 with data 1 → irq=0. W1C in the same cycle as a new busy fall → bit stays 1.
- Offset 0x400+8*CFG_DEPTH, offset 0x030, and reg_wen&reg_ren together → each acked with err=1. An address outside the page → no ack.
- CTRL bit1 set, then img_expired_flg pulse → nn_img_new 1→0, IRQ_STAT[1]=1. With CFG_DEPTH=1, DW=32 build → CFG[1] access errs.
